// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch / load-store memory port arbiter.
// Holds the FSM states, grant sources, the fixed fetch mask and a counter sizing helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        LS_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } grant_src_t;

    localparam logic [3:0] FETCH_MASK = 4'b1111;

    // Bits needed to count up to limit, never less than one.
    function automatic int unsigned ctr_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access watchdog: counts stalled busy cycles and flags the cycle in which the
// TIMEOUT-th consecutive cycle without mem_valid is reached.
module mem_timeout_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = ctr_width(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    // The increment on this edge would make the count equal TIMEOUT.
    assign expired = en && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store, with
// alternating priority under contention and a watchdog that aborts silent accesses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        ls_req,
    input  logic        ls_we_re,
    input  logic [3:0]  ls_mask,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_valid,
    output logic        mem_request,
    output logic        mem_we_re,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic        stall,
    output logic        err,
    output logic        err_src
);

    arb_state_t  state;
    arb_state_t  next_state;
    grant_src_t  last_grant;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic        we_q;
    logic        grant_if;
    logic        grant_ls;
    logic        done;
    logic        timed_out;
    logic        busy;
    logic        expired;

    assign busy = (state != IDLE);

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant_if | grant_ls),
        .en      (busy & ~mem_valid),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Under contention LS wins unless it was the last one served.
    always_comb begin
        next_state = state;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        done       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (ls_req && (!if_req || last_grant == SRC_IF)) begin
                    grant_ls   = 1'b1;
                    next_state = LS_BUSY;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    next_state = IF_BUSY;
                end
            end
            IF_BUSY, LS_BUSY: begin
                if (mem_valid) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SRC_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            mask_q     <= '0;
            wdata_q    <= '0;
        end else if (grant_if) begin
            last_grant <= SRC_IF;
            addr_q     <= if_addr;
            we_q       <= 1'b0;
            mask_q     <= FETCH_MASK;
            wdata_q    <= '0;
        end else if (grant_ls) begin
            last_grant <= SRC_LS;
            addr_q     <= ls_addr;
            we_q       <= ls_we_re;
            mask_q     <= ls_mask;
            wdata_q    <= ls_wdata;
        end
    end

    // Writes also return mem_rdata and pulse ls_valid so the core sees one completion path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata <= '0;
            ls_rdata <= '0;
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            err      <= 1'b0;
            err_src  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            ls_valid <= 1'b0;
            err      <= timed_out;
            if (done && state == IF_BUSY) begin
                if_rdata <= mem_rdata;
                if_valid <= 1'b1;
            end
            if (done && state == LS_BUSY) begin
                ls_rdata <= mem_rdata;
                ls_valid <= 1'b1;
            end
            if (timed_out) begin
                err_src <= (state == LS_BUSY);
            end
        end
    end

    assign mem_request = busy;
    assign mem_address = addr_q;
    assign mem_we_re   = we_q;
    assign mem_mask    = mask_q;
    assign mem_wdata   = wdata_q;
    assign stall       = (if_req & ~if_valid) | (ls_req & ~ls_valid);

endmodule
